logic_gate_unit: RTL and testbench

Parametrised, registered bitwise logic unit. It accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake, computes one of eight bitwise gate functions (NOT through XNOR), and queues results in a DEPTH-entry output FIFO drained by a second valid/ready handshake. It replaces the single-bit, delay-modelled gates in the lab set with one clocked, back-pressured block that later datapath experiments can instantiate directly.

---
 rtl/logic_gate_unit.sv | 133 +++++++++++++
 tb/tb_logic_gate_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: eight gate functions on two WIDTH-bit operands,
// with results queued in a DEPTH-entry FIFO behind valid/ready handshakes.

// Generic circular-buffer FIFO with a registered occupancy count.
// Latency: a push at edge N is visible at the head after edge N; no fall-through.
// Backpressure: push_rdy drops only when full and the consumer is not popping.
module lgu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  output logic                         push_rdy,
  input  logic [WIDTH-1:0]             push_dat,
  output logic                         pop_vld,
  input  logic                         pop_rdy,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  assign full     = (count_q == CNT_FULL);
  // A pop in the same cycle frees the slot the push needs, so full still accepts.
  assign push_rdy = !full || pop_rdy;
  assign pop_vld  = (count_q != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  assign count    = count_q;
  assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// Top: decodes the opcode into one of eight bitwise gates and enqueues the result.
// Latency: one edge from accepted operands to out_valid/out_data.
// Backpressure: in_ready = not full, or out_ready (combinational pass-through).
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  logic [WIDTH-1:0] result_d;

  always_comb begin
    result_d = '0;
    unique case (in_op)
      3'b000: result_d = ~in_a;
      3'b001: result_d = in_a & in_b;
      3'b010: result_d = in_a | in_b;
      3'b011: result_d = in_a ^ in_b;
      3'b100: result_d = ~(in_a & in_b);
      3'b101: result_d = ~(in_a | in_b);
      3'b110: result_d = ~(in_a ^ in_b);
      3'b111: result_d = in_a;
      default: result_d = '0;
    endcase
  end

  lgu_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (result_d),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .count    (count)
  );

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: directed scenarios plus a randomized soak.
module tb_logic_gate_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 in_op;
  logic [WIDTH-1:0]           in_a;
  logic [WIDTH-1:0]           in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] count;

  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  logic_gate_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference gate table, straight from the opcode list.
  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  // One clock of stimulus: decide acceptance on the falling edge, record at the rising edge.
  task automatic step(input bit use_fixed, input logic [WIDTH-1:0] fixed_v);
    bit               acc;
    logic [WIDTH-1:0] e;
    @(negedge clk);
    acc = !rst && in_valid && in_ready;
    e   = use_fixed ? fixed_v : ref_gate(in_op, in_a, in_b);
    @(posedge clk);
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compares DUT state against the model queue every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", int'(count), exp_q.size());
      check("count_bound", int'(count <= DEPTH), 1);
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("in_ready", int'(in_ready), int'((exp_q.size() < DEPTH) || out_ready));
      if (exp_q.size() != 0) begin
        check("out_data", int'(out_data), int'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] sweep_exp [8];
    sweep_exp = '{8'h35, 8'h4A, 8'hDF, 8'h95, 8'hB5, 8'h20, 8'h6A, 8'hCA};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Opcode sweep, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = 3'(i); in_a = 8'hCA; in_b = 8'h5F;
      step(1'b1, sweep_exp[i]);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // Fill with the consumer stalled; the fifth set must be held off.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 7));
      in_a = 8'($urandom); in_b = 8'($urandom);
      step(1'b0, '0);
      if (i == 3) check("full_in_ready", int'(in_ready), 0);
    end
    check("full_count", int'(count), DEPTH);

    // Full with simultaneous push and pop, then drain.
    out_ready = 1'b1;
    step(1'b0, '0);
    check("full_pushpop_count", int'(count), DEPTH);
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, '0);
    check("drained_out_valid", int'(out_valid), 0);
    check("drained_count", int'(count), 0);

    // Mid-cycle reset with two entries stored.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 7));
      in_a = 8'($urandom); in_b = 8'($urandom);
      step(1'b0, '0);
    end
    in_valid = 1'b0;
    check("pre_rst_count", int'(count), 2);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    in_valid = 1'b1; out_ready = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 3'd2;
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    step(1'b0, '0);
    check("post_rst_count", int'(count), 0);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_op = 3'($urandom_range(0, 7));
      in_a  = 8'($urandom);
      in_b  = 8'($urandom);
      step(1'b0, '0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0);
    check("final_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
